mem_arb: RTL and testbench

Two-requester memory arbiter sharing a single core memory port between instruction fetch and load/store. Sits between the fetch unit (fch_req/fch_rsp) and the LSU (ldst_req/ldst_rsp) on one side and the core's unified memory port (ldst_req/ldst_rsp types) on the other. Converts fetches into word loads, arbitrates round-robin, tracks outstanding transactions in issue order and steers in-order responses back to the originator.

---
 rtl/mem_arb_pkg.sv | 48 ++++
 rtl/mem_arb_ord_fifo.sv | 60 ++++++
 rtl/mem_arb.sv | 123 ++++++++++++
 tb/tb_mem_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Each handshake channel is a packed payload struct carrying its own vld bit;
// the matching rdy travels on a separate scalar port in the opposite direction.
package mem_arb_pkg;

    localparam int RV_AW   = 32;          // memory address width
    localparam int RV_XLEN = 32;          // data / instruction width
    localparam int RV_PCW  = 32;          // program counter width
    localparam int STRB_W  = RV_XLEN / 8; // byte strobes per word

    localparam logic [STRB_W-1:0] MEM_STRB_ALL = '1;

    // Originator of an issued memory transaction.
    typedef enum logic {
        SRC_FCH  = 1'b0,
        SRC_LDST = 1'b1
    } mem_src_e;

    typedef struct packed {
        logic              vld;
        logic [RV_PCW-1:0] pc;
    } fch_req_if_t;

    typedef struct packed {
        logic               vld;
        logic [RV_XLEN-1:0] ir;
    } fch_rsp_if_t;

    typedef struct packed {
        logic               vld;
        logic [RV_AW-1:0]   addr;
        logic               st;
        logic [RV_XLEN-1:0] data;
        logic [STRB_W-1:0]  strobe;
    } ldst_req_if_t;

    typedef struct packed {
        logic               vld;
        logic [RV_XLEN-1:0] data;
        logic               ok;
    } ldst_rsp_if_t;

    // Fetch addresses are the pc, zero-extended or truncated to the bus width.
    function automatic logic [RV_AW-1:0] pc_to_addr(input logic [RV_PCW-1:0] pc);
        return RV_AW'(pc);
    endfunction

endpackage

// File: rtl/mem_arb_ord_fifo.sv
// Order FIFO: remembers which requester owns each outstanding memory
// transaction, in issue order, so in-order responses can be steered back.
module mem_arb_ord_fifo
    import mem_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  mem_src_e         push_src,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output mem_src_e         head,
    output logic [CNT_W-1:0] cnt
);

    mem_src_e         slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Capture the source tag of each accepted transaction.
    // NOTE: storage has no reset; an entry is only read after it was written, and cnt guards validity.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_src;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave cnt unchanged.
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = slots[rd_ptr];

endmodule

// File: rtl/mem_arb.sv
// Two-requester memory arbiter: fetch and load/store share one memory port.
// Fetches become word loads, conflicts resolve round-robin, a stalled request
// keeps its grant until accepted, and in-order responses are steered back to
// their originator using the order FIFO.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter  int MAX_OUTST = 2,
    localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  fch_req_if_t      fch_req,
    output logic             fch_req_rdy,
    output fch_rsp_if_t      fch_rsp,
    input  logic             fch_rsp_rdy,
    input  ldst_req_if_t     ls_req,
    output logic             ls_req_rdy,
    output ldst_rsp_if_t     ls_rsp,
    input  logic             ls_rsp_rdy,
    output ldst_req_if_t     mem_req,
    input  logic             mem_req_rdy,
    input  ldst_rsp_if_t     mem_rsp,
    output logic             mem_rsp_rdy,
    output logic             fch_err,
    output logic [CNT_W-1:0] outst_cnt
);

    logic     lock;
    mem_src_e lock_src;
    mem_src_e rr_last;
    mem_src_e sel_src;
    logic     issue_vld;
    logic     issue_hs;
    logic     rsp_hs;
    logic     ord_full;
    logic     ord_empty;
    mem_src_e ord_head;

    // Pick the source: a held grant wins, else the lone requester, else the one not granted last.
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        sel_src = SRC_FCH;
        if (lock) begin
            sel_src = lock_src;
        end else if (fch_req.vld && ls_req.vld) begin
            sel_src = (rr_last == SRC_LDST) ? SRC_FCH : SRC_LDST;
        end else if (ls_req.vld) begin
            sel_src = SRC_LDST;
        end
    end

    // Full is taken from the registered count only, so a pop frees a slot next cycle.
    assign issue_vld = (fch_req.vld | ls_req.vld) & ~ord_full;
    assign issue_hs  = issue_vld & mem_req_rdy;

    // Build the outgoing packet: forward the LSU request or turn the fetch into a word load.
    always_comb begin
        mem_req = ls_req;
        if (sel_src == SRC_FCH) begin
            mem_req.addr   = pc_to_addr(fch_req.pc);
            mem_req.st     = 1'b0;
            mem_req.data   = '0;
            mem_req.strobe = MEM_STRB_ALL;
        end
        mem_req.vld = issue_vld;
    end

    assign fch_req_rdy = issue_hs & (sel_src == SRC_FCH);
    assign ls_req_rdy  = issue_hs & (sel_src == SRC_LDST);

    // Hold the grant across memory back-pressure; remember the winner on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            lock_src <= SRC_FCH;
            rr_last  <= SRC_LDST;
        end else if (issue_hs) begin
            lock    <= 1'b0;
            rr_last <= sel_src;
        end else if (issue_vld) begin
            lock     <= 1'b1;
            lock_src <= sel_src;
        end
    end

    mem_arb_ord_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_ord_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (issue_hs),
        .push_src (sel_src),
        .pop      (rsp_hs),
        .full     (ord_full),
        .empty    (ord_empty),
        .head     (ord_head),
        .cnt      (outst_cnt)
    );

    // Steer the in-order response to the owner of the oldest outstanding transaction.
    always_comb begin
        fch_rsp     = '0;
        ls_rsp      = '0;
        mem_rsp_rdy = 1'b0;
        fch_rsp.ir  = mem_rsp.data;
        ls_rsp.data = mem_rsp.data;
        ls_rsp.ok   = mem_rsp.ok;
        if (!ord_empty) begin
            if (ord_head == SRC_FCH) begin
                fch_rsp.vld = mem_rsp.vld;
                mem_rsp_rdy = fch_rsp_rdy;
            end else begin
                ls_rsp.vld  = mem_rsp.vld;
                mem_rsp_rdy = ls_rsp_rdy;
            end
        end
    end

    assign rsp_hs  = mem_rsp.vld & mem_rsp_rdy;
    assign fch_err = fch_rsp.vld & fch_rsp_rdy & ~mem_rsp.ok;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model
// (queue of outstanding transactions, last winner, held grant).
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int MAX_OUTST = 2;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    fch_req_if_t      fch_req;
    logic             fch_req_rdy;
    fch_rsp_if_t      fch_rsp;
    logic             fch_rsp_rdy;
    ldst_req_if_t     ls_req;
    logic             ls_req_rdy;
    ldst_rsp_if_t     ls_rsp;
    logic             ls_rsp_rdy;
    ldst_req_if_t     mem_req;
    logic             mem_req_rdy;
    ldst_rsp_if_t     mem_rsp;
    logic             mem_rsp_rdy;
    logic             fch_err;
    logic [CNT_W-1:0] outst_cnt;

    always #5 clk = ~clk;

    mem_arb #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fch_req     (fch_req),
        .fch_req_rdy (fch_req_rdy),
        .fch_rsp     (fch_rsp),
        .fch_rsp_rdy (fch_rsp_rdy),
        .ls_req      (ls_req),
        .ls_req_rdy  (ls_req_rdy),
        .ls_rsp      (ls_rsp),
        .ls_rsp_rdy  (ls_rsp_rdy),
        .mem_req     (mem_req),
        .mem_req_rdy (mem_req_rdy),
        .mem_rsp     (mem_rsp),
        .mem_rsp_rdy (mem_rsp_rdy),
        .fch_err     (fch_err),
        .outst_cnt   (outst_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by the randomized phase: loads return a hash of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a, input logic st);
        return st ? 32'h0 : ((a ^ 32'hC0DE_0000) + {a[15:0], a[31:16]});
    endfunction

    typedef struct {
        mem_src_e    src;
        logic [31:0] addr;
        logic        st;
    } txn_t;

    txn_t        outst_q[$];
    logic [31:0] rsp_data_q[$];
    bit          held_v     = 0;
    mem_src_e    held_src   = SRC_FCH;
    mem_src_e    last_src   = SRC_LDST;
    bit          check_data = 0;
    bit          fch_hs, ls_hs, mrsp_hs;

    // Compare process: derive expected outputs from the arbitration rules and the model queue.
    always @(negedge clk) begin : compare
        bit          exp_vld, head_f, head_l, exp_pop;
        mem_src_e    who;
        logic [31:0] e_addr, e_data;
        logic        e_st;
        logic [3:0]  e_strb;
        if (!rst_n) begin
            outst_q.delete();
            rsp_data_q.delete();
            held_v   = 0;
            last_src = SRC_LDST;
        end
        exp_vld = (fch_req.vld || ls_req.vld) && (outst_q.size() < MAX_OUTST);
        if (held_v)                           who = held_src;
        else if (fch_req.vld && ls_req.vld)   who = (last_src == SRC_FCH) ? SRC_LDST : SRC_FCH;
        else                                  who = ls_req.vld ? SRC_LDST : SRC_FCH;
        if (who == SRC_FCH) begin
            e_addr = fch_req.pc; e_st = 1'b0; e_data = 32'h0; e_strb = 4'hF;
        end else begin
            e_addr = ls_req.addr; e_st = ls_req.st; e_data = ls_req.data; e_strb = ls_req.strobe;
        end
        check("mem_req_vld", mem_req.vld, exp_vld);
        check("outst_cnt", outst_cnt, outst_q.size());
        if (exp_vld) begin
            check("mem_req_addr", mem_req.addr, e_addr);
            check("mem_req_st", mem_req.st, e_st);
            check("mem_req_data", mem_req.data, e_data);
            check("mem_req_strb", mem_req.strobe, e_strb);
        end
        fch_hs = exp_vld && who == SRC_FCH && mem_req_rdy;
        ls_hs  = exp_vld && who == SRC_LDST && mem_req_rdy;
        check("fch_req_rdy", fch_req_rdy, fch_hs);
        check("ls_req_rdy", ls_req_rdy, ls_hs);
        head_f  = outst_q.size() > 0 && outst_q[0].src == SRC_FCH;
        head_l  = outst_q.size() > 0 && outst_q[0].src == SRC_LDST;
        exp_pop = mem_rsp.vld && ((head_f && fch_rsp_rdy) || (head_l && ls_rsp_rdy));
        check("fch_rsp_vld", fch_rsp.vld, head_f && mem_rsp.vld);
        check("ls_rsp_vld", ls_rsp.vld, head_l && mem_rsp.vld);
        check("mem_rsp_rdy", mem_rsp_rdy, head_f ? fch_rsp_rdy : (head_l ? ls_rsp_rdy : 1'b0));
        check("fch_err", fch_err, head_f && mem_rsp.vld && fch_rsp_rdy && !mem_rsp.ok);
        if (head_f && mem_rsp.vld) begin
            check("fch_rsp_ir", fch_rsp.ir, mem_rsp.data);
            if (check_data) check("fch_ir_order", fch_rsp.ir, mem_fn(outst_q[0].addr, 1'b0));
        end
        if (head_l && mem_rsp.vld) begin
            check("ls_rsp_data", ls_rsp.data, mem_rsp.data);
            check("ls_rsp_ok", ls_rsp.ok, mem_rsp.ok);
            if (check_data) check("ls_data_order", ls_rsp.data, mem_fn(outst_q[0].addr, outst_q[0].st));
        end
        mrsp_hs = exp_pop;
        if (rst_n) begin
            if (exp_pop) void'(outst_q.pop_front());
            if (exp_vld && mem_req_rdy) begin
                outst_q.push_back('{src: who, addr: e_addr, st: e_st});
                rsp_data_q.push_back(mem_fn(e_addr, e_st));
                last_src = who;
                held_v   = 0;
            end else if (exp_vld) begin
                held_v   = 1;
                held_src = who;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [31:0] alt_data [4];

    initial begin
        fch_req = '0; ls_req = '0; mem_rsp = '0;
        mem_req_rdy = 0; fch_rsp_rdy = 0; ls_rsp_rdy = 0;
        alt_data[0] = 32'hA; alt_data[1] = 32'hB; alt_data[2] = 32'hC; alt_data[3] = 32'hD;
        tick(); tick();
        settle();
        check("rst_mem_vld", mem_req.vld, 0);
        check("rst_cnt", outst_cnt, 0);
        tick();
        rst_n = 1;

        // Fetch only: converted to a word load, response goes to fetch.
        fch_req.vld = 1; fch_req.pc = 32'h100; mem_req_rdy = 1; settle();
        check("t1_addr", mem_req.addr, 32'h100);
        check("t1_st", mem_req.st, 0);
        check("t1_strb", mem_req.strobe, 4'hF);
        check("t1_rdy", fch_req_rdy, 1);
        tick();
        fch_req.vld = 0; mem_rsp.vld = 1; mem_rsp.data = 32'h13; mem_rsp.ok = 1;
        fch_rsp_rdy = 1; ls_rsp_rdy = 1; settle();
        check("t1_ir_vld", fch_rsp.vld, 1);
        check("t1_ir", fch_rsp.ir, 32'h13);
        check("t1_ls_vld", ls_rsp.vld, 0);
        tick();
        mem_rsp.vld = 0;

        // Lock: stalled fetch keeps the grant although round-robin would favour the LSU.
        fch_req.vld = 1; fch_req.pc = 32'h200; mem_req_rdy = 0; settle();
        check("lk_addr0", mem_req.addr, 32'h200);
        for (int i = 0; i < 2; i++) begin
            tick();
            ls_req.vld = 1; ls_req.addr = 32'h300; ls_req.st = 1; ls_req.data = 32'h55; ls_req.strobe = 4'h3;
            settle();
            check("lk_addr_hold", mem_req.addr, 32'h200);
            check("lk_ls_rdy", ls_req_rdy, 0);
        end
        tick();
        mem_req_rdy = 1; settle();
        check("lk_fch_rdy", fch_req_rdy, 1);
        check("lk_ls_rdy_hs", ls_req_rdy, 0);
        tick();
        fch_req.vld = 0; settle();
        check("lk_ls_addr", mem_req.addr, 32'h300);
        check("lk_ls_grant", ls_req_rdy, 1);
        tick();
        ls_req.vld = 0; mem_rsp.vld = 1; mem_rsp.data = 32'h1; settle();
        check("lk_rsp_fch", fch_rsp.vld, 1);
        tick();
        mem_rsp.data = 32'h2; settle();
        check("lk_rsp_ls", ls_rsp.vld, 1);
        check("lk_rsp_ls_data", ls_rsp.data, 32'h2);
        tick();
        mem_rsp.vld = 0;

        // Alternation: both valid every cycle, responses one cycle behind.
        for (int k = 0; k < 5; k++) begin
            fch_req.vld = (k < 4); fch_req.pc = 32'h1000 + 32'(4 * k);
            ls_req.vld = (k < 4); ls_req.addr = 32'h2000 + 32'(4 * k); ls_req.st = 0;
            mem_rsp.vld = (k >= 1); mem_rsp.ok = 1;
            if (k >= 1) mem_rsp.data = alt_data[k-1];
            settle();
            if (k < 4) begin
                check("alt_fch_grant", fch_req_rdy, (k % 2) == 0);
                check("alt_ls_grant", ls_req_rdy, (k % 2) == 1);
            end
            if (k >= 1) begin
                check("alt_fch_rsp", fch_rsp.vld, ((k - 1) % 2) == 0);
                check("alt_ls_rsp", ls_rsp.vld, ((k - 1) % 2) == 1);
            end
            tick();
        end
        mem_rsp.vld = 0;

        // Full: two outstanding block a third; a pop frees a slot only next cycle.
        fch_req.vld = 1; fch_req.pc = 32'h600; settle();
        check("fl_issue1", fch_req_rdy, 1);
        tick();
        fch_req.vld = 0; ls_req.vld = 1; ls_req.addr = 32'h700; settle();
        check("fl_issue2", ls_req_rdy, 1);
        tick();
        ls_req.vld = 0; fch_req.vld = 1; fch_req.pc = 32'h604; settle();
        check("fl_blocked", fch_req_rdy, 0);
        check("fl_memvld", mem_req.vld, 0);
        check("fl_cnt2", outst_cnt, 2);
        tick();
        mem_rsp.vld = 1; mem_rsp.data = 32'h11; settle();
        check("fl_no_bypass", fch_req_rdy, 0);
        check("fl_pop_fch", fch_rsp.vld, 1);
        tick();
        mem_rsp.data = 32'h22; settle();
        check("fl_reopen", fch_req_rdy, 1);
        check("fl_pop_ls", ls_rsp.vld, 1);
        tick();
        mem_rsp.vld = 0; fch_req.pc = 32'h608; settle();
        check("fl_pushpop_cnt", outst_cnt, 1);
        tick();
        fch_req.pc = 32'h60C; settle();
        check("fl_cnt_full", outst_cnt, 2);
        check("fl_blocked2", fch_req_rdy, 0);
        tick();
        fch_req.vld = 0; mem_rsp.vld = 1; mem_rsp.data = 32'h33;
        tick();
        mem_rsp.data = 32'h44;
        tick();
        mem_rsp.vld = 0;

        // Error responses: fetch flags fch_err, LSU passes ok through.
        fch_req.vld = 1; fch_req.pc = 32'h800;
        tick();
        fch_req.vld = 0; mem_rsp.vld = 1; mem_rsp.data = 32'hDEAD; mem_rsp.ok = 0; settle();
        check("er_ir", fch_rsp.ir, 32'hDEAD);
        check("er_pulse", fch_err, 1);
        tick();
        mem_rsp.vld = 0; mem_rsp.ok = 1; settle();
        check("er_pulse_end", fch_err, 0);
        tick();
        ls_req.vld = 1; ls_req.st = 1; ls_req.addr = 32'h900;
        tick();
        ls_req.vld = 0; mem_rsp.vld = 1; mem_rsp.data = 32'h0; mem_rsp.ok = 0; settle();
        check("er_ls_vld", ls_rsp.vld, 1);
        check("er_ls_ok", ls_rsp.ok, 0);
        check("er_ls_noerr", fch_err, 0);
        tick();
        mem_rsp.ok = 1; mem_rsp.data = 32'hBAD; settle();
        check("sp_rdy", mem_rsp_rdy, 0);
        check("sp_fch_vld", fch_rsp.vld, 0);
        tick();
        mem_rsp.vld = 0;

        // Reset with two outstanding transactions.
        fch_req.vld = 1; fch_req.pc = 32'hA00; ls_req.vld = 1; ls_req.addr = 32'hB00; ls_req.st = 0;
        tick();
        tick();
        fch_req.vld = 0; ls_req.vld = 0; fch_rsp_rdy = 0; mem_rsp.vld = 1; mem_rsp.data = 32'h77; settle();
        check("rs_cnt2", outst_cnt, 2);
        check("rs_stall_vld", fch_rsp.vld, 1);
        rst_n = 0; #1;
        check("rs_fch_vld", fch_rsp.vld, 0);
        check("rs_mrsp_rdy", mem_rsp_rdy, 0);
        check("rs_cnt0", outst_cnt, 0);
        tick();
        mem_rsp.vld = 0; fch_rsp_rdy = 1;
        tick();
        rst_n = 1; fch_req.vld = 1; fch_req.pc = 32'hC00; settle();
        check("rs_first_rdy", fch_req_rdy, 1);
        tick();
        fch_req.vld = 0; settle();
        check("rs_cnt1", outst_cnt, 1);
        tick();
        mem_rsp.vld = 1; mem_rsp.data = 32'hC0; settle();
        check("rs_rsp_fch", fch_rsp.vld, 1);
        tick();
        mem_rsp.vld = 0;
        tick();

        // Randomized traffic with a back-pressured responder.
        rsp_data_q.delete();
        check_data = 1;
        fch_hs = 0; ls_hs = 0; mrsp_hs = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!fch_req.vld || fch_hs) begin
                fch_req.vld = ($urandom_range(0, 99) < 60);
                fch_req.pc  = $urandom & 32'hFFFF_FFFC;
            end
            if (!ls_req.vld || ls_hs) begin
                ls_req.vld    = ($urandom_range(0, 99) < 60);
                ls_req.addr   = $urandom;
                ls_req.st     = 1'($urandom_range(0, 1));
                ls_req.data   = $urandom;
                ls_req.strobe = 4'($urandom_range(0, 15));
            end
            if (c > 3800) begin
                fch_req.vld = 0; ls_req.vld = 0;
            end
            mem_req_rdy = ($urandom_range(0, 99) < 70);
            fch_rsp_rdy = ($urandom_range(0, 99) < 75);
            ls_rsp_rdy  = ($urandom_range(0, 99) < 75);
            if (mem_rsp.vld && mrsp_hs) mem_rsp.vld = 0;
            if (!mem_rsp.vld && rsp_data_q.size() > 0 && $urandom_range(0, 99) < 70) begin
                mem_rsp.vld  = 1;
                mem_rsp.data = rsp_data_q.pop_front();
                mem_rsp.ok   = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        settle();
        check("drain_cnt", outst_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
